apb_frame_packer: RTL and testbench

Parametrised successor to the RAH-to-APB data controller. It accepts decoded RAH frames (a header, then payload frames) through a valid/ready handshake and splits each payload frame into CHUNK_WIDTH chunks. It packs those chunks into APB_DATA_WIDTH words and issues one addressed, slave-selected request per word to the APB master, with back-pressure. Config frames bypass packing and leave through a separate config handshake.

---
 rtl/apb_frame_packer.sv | 223 ++++++++++++++++++++++
 tb/tb_apb_frame_packer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_frame_packer.sv
// apb_frame_packer: accepts decoded RAH frames, splits payload frames into chunks, packs the
// chunks into APB words and issues one addressed, slave-selected request per word. Read
// transactions issue back-to-back requests with zero data. Config frames bypass packing and
// leave through a dedicated config handshake.
module apb_frame_packer #(
    parameter int unsigned RAH_PACKET_WIDTH  = 48,
    parameter int unsigned CHUNK_WIDTH       = 16,
    parameter int unsigned APB_DATA_WIDTH    = 32,
    parameter int unsigned CONFIG_DATA_WIDTH = 40,
    parameter int unsigned LENGTH_WIDTH      = 7,
    parameter int unsigned SLV_ID_WIDTH      = 7,
    parameter int unsigned TOTAL_SLAVE       = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         frame_valid,
    output logic                         frame_ready,
    input  logic                         first_frame,
    input  logic                         cfg_sel,
    input  logic                         read_write_sel,
    input  logic [SLV_ID_WIDTH-1:0]      slv_id,
    input  logic [LENGTH_WIDTH-1:0]      length,
    input  logic [RAH_PACKET_WIDTH-1:0]  wr_data,
    output logic                         req_valid,
    input  logic                         req_ready,
    output logic                         req_write,
    output logic [TOTAL_SLAVE-1:0]       req_sel,
    output logic [LENGTH_WIDTH-1:0]      req_addr,
    output logic [APB_DATA_WIDTH-1:0]    req_data,
    output logic                         req_last,
    output logic                         cfg_valid,
    input  logic                         cfg_ready,
    output logic [CONFIG_DATA_WIDTH-1:0] cfg_data,
    output logic                         err
);

    // Chunks per frame and chunks per word.
    localparam int unsigned CPF   = RAH_PACKET_WIDTH / CHUNK_WIDTH;
    localparam int unsigned CPW   = APB_DATA_WIDTH / CHUNK_WIDTH;
    localparam int unsigned PTR_W = $clog2(CPF + 1);
    localparam int unsigned CNT_W = (CPW > 1) ? $clog2(CPW) : 1;

    // A pointer value of CPF marks the frame buffer as empty.
    localparam logic [PTR_W-1:0] PTR_EMPTY = PTR_W'(CPF);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CPW - 1);

    typedef enum logic [1:0] {StIdle, StWr, StRd, StCfg} state_e;

    state_e                        state_q, state_d;
    logic                          rdy_en_q;
    logic [RAH_PACKET_WIDTH-1:0]   buf_q, buf_d;
    logic [PTR_W-1:0]              ptr_q, ptr_d;
    logic [APB_DATA_WIDTH-1:0]     asm_q, asm_d;
    logic [CNT_W-1:0]              asm_cnt_q, asm_cnt_d;
    logic                          req_valid_q, req_valid_d;
    logic [APB_DATA_WIDTH-1:0]     req_data_q, req_data_d;
    logic [LENGTH_WIDTH-1:0]       addr_q, addr_d;
    logic [LENGTH_WIDTH-1:0]       remaining_q, remaining_d;
    logic [TOTAL_SLAVE-1:0]        sel_q, sel_d;
    logic                          dir_q, dir_d;
    logic [CONFIG_DATA_WIDTH-1:0]  cfg_data_q, cfg_data_d;
    logic                          err_q, err_d;

    logic                          frame_fire;
    logic                          req_fire;
    logic                          take;
    logic [CHUNK_WIDTH-1:0]        chunk;
    logic [APB_DATA_WIDTH-1:0]     asm_shift;

    // Handshake qualifiers and the chunk datapath (buffer shifts left, MSB chunk leaves first).
    always_comb begin
        frame_ready = rdy_en_q &&
                      ((state_q == StIdle) || ((state_q == StWr) && (ptr_q == PTR_EMPTY)));
        frame_fire  = frame_valid && frame_ready;
        req_fire    = req_valid_q && req_ready;
        // A chunk moves only when no request is left pending after this edge.
        take        = (state_q == StWr) && (ptr_q != PTR_EMPTY) && (!req_valid_q || req_ready);
        chunk       = buf_q[RAH_PACKET_WIDTH-1 -: CHUNK_WIDTH];
        asm_shift   = (asm_q << CHUNK_WIDTH) | APB_DATA_WIDTH'(chunk);
    end

    // Next-state logic for the controller, frame buffer and word assembler.
    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        ptr_d       = ptr_q;
        asm_d       = asm_q;
        asm_cnt_d   = asm_cnt_q;
        req_valid_d = req_valid_q;
        req_data_d  = req_data_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        sel_d       = sel_q;
        dir_d       = dir_q;
        cfg_data_d  = cfg_data_q;
        err_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (frame_fire) begin
                    if (cfg_sel) begin
                        cfg_data_d = wr_data[CONFIG_DATA_WIDTH-1:0];
                        state_d    = StCfg;
                    end else if (first_frame) begin
                        if (32'(slv_id) >= TOTAL_SLAVE) begin
                            err_d = 1'b1;
                        end else if (length != '0) begin
                            sel_d       = TOTAL_SLAVE'(1) << slv_id;
                            addr_d      = wr_data[LENGTH_WIDTH-1:0];
                            remaining_d = length;
                            dir_d       = read_write_sel;
                            if (read_write_sel) begin
                                state_d = StWr;
                            end else begin
                                state_d     = StRd;
                                req_valid_d = 1'b1;
                                req_data_d  = '0;
                            end
                        end
                    end
                    // Non-header frames in idle are dropped.
                end
            end
            StWr: begin
                if (frame_fire) begin
                    buf_d = wr_data;
                    ptr_d = '0;
                end
                if (req_fire) begin
                    addr_d      = addr_q + LENGTH_WIDTH'(1);
                    remaining_d = remaining_q - LENGTH_WIDTH'(1);
                    req_valid_d = 1'b0;
                end
                if (take) begin
                    buf_d = buf_q << CHUNK_WIDTH;
                    ptr_d = ptr_q + PTR_W'(1);
                    if (asm_cnt_q == CNT_LAST) begin
                        asm_d       = '0;
                        asm_cnt_d   = '0;
                        req_valid_d = 1'b1;
                        req_data_d  = asm_shift;
                    end else begin
                        asm_d     = asm_shift;
                        asm_cnt_d = asm_cnt_q + CNT_W'(1);
                    end
                end
                // Final handshake: drop leftover chunks and any partial word.
                if (req_fire && (remaining_q == LENGTH_WIDTH'(1))) begin
                    state_d     = StIdle;
                    ptr_d       = PTR_EMPTY;
                    asm_d       = '0;
                    asm_cnt_d   = '0;
                    req_valid_d = 1'b0;
                end
            end
            StRd: begin
                if (req_fire) begin
                    addr_d      = addr_q + LENGTH_WIDTH'(1);
                    remaining_d = remaining_q - LENGTH_WIDTH'(1);
                    if (remaining_q == LENGTH_WIDTH'(1)) begin
                        req_valid_d = 1'b0;
                        state_d     = StIdle;
                    end
                end
            end
            StCfg: begin
                if (cfg_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rdy_en_q    <= 1'b0;
            buf_q       <= '0;
            ptr_q       <= PTR_EMPTY;
            asm_q       <= '0;
            asm_cnt_q   <= '0;
            req_valid_q <= 1'b0;
            req_data_q  <= '0;
            addr_q      <= '0;
            remaining_q <= '0;
            sel_q       <= '0;
            dir_q       <= 1'b0;
            cfg_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdy_en_q    <= 1'b1;
            buf_q       <= buf_d;
            ptr_q       <= ptr_d;
            asm_q       <= asm_d;
            asm_cnt_q   <= asm_cnt_d;
            req_valid_q <= req_valid_d;
            req_data_q  <= req_data_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            sel_q       <= sel_d;
            dir_q       <= dir_d;
            cfg_data_q  <= cfg_data_d;
            err_q       <= err_d;
        end
    end

    // Registered outputs; req_last only qualifies a presented request.
    always_comb begin
        req_valid = req_valid_q;
        req_write = dir_q;
        req_sel   = sel_q;
        req_addr  = addr_q;
        req_data  = req_data_q;
        req_last  = req_valid_q && (remaining_q == LENGTH_WIDTH'(1));
        cfg_valid = (state_q == StCfg);
        cfg_data  = cfg_data_q;
        err       = err_q;
    end

endmodule

// File: tb/tb_apb_frame_packer.sv
// Directed testbench for apb_frame_packer with hand-computed expected values.
module tb_apb_frame_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        frame_valid = 1'b0;
    logic        frame_ready;
    logic        first_frame = 1'b0;
    logic        cfg_sel = 1'b0;
    logic        read_write_sel = 1'b0;
    logic [6:0]  slv_id = '0;
    logic [6:0]  length = '0;
    logic [47:0] wr_data = '0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic        req_write;
    logic [3:0]  req_sel;
    logic [6:0]  req_addr;
    logic [31:0] req_data;
    logic        req_last;
    logic        cfg_valid;
    logic        cfg_ready = 1'b0;
    logic [39:0] cfg_data;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;

    apb_frame_packer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .frame_valid    (frame_valid),
        .frame_ready    (frame_ready),
        .first_frame    (first_frame),
        .cfg_sel        (cfg_sel),
        .read_write_sel (read_write_sel),
        .slv_id         (slv_id),
        .length         (length),
        .wr_data        (wr_data),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_sel        (req_sel),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .req_last       (req_last),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_data       (cfg_data),
        .err            (err)
    );

    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_header(input logic [6:0] sid, input logic [6:0] len,
                               input logic [6:0] addr, input logic rw);
        frame_valid    = 1'b1;
        first_frame    = 1'b1;
        cfg_sel        = 1'b0;
        slv_id         = sid;
        length         = len;
        read_write_sel = rw;
        wr_data        = {41'd0, addr};
        tick();
        frame_valid = 1'b0;
        first_frame = 1'b0;
    endtask

    task automatic send_frame(input logic [47:0] data);
        frame_valid = 1'b1;
        first_frame = 1'b0;
        cfg_sel     = 1'b0;
        wr_data     = data;
        tick();
        frame_valid = 1'b0;
    endtask

    task automatic check_req(input string tag, input logic [31:0] data, input logic [6:0] addr,
                             input logic [3:0] sel, input logic last);
        check({tag, "_valid"}, 64'(req_valid), 64'(1'b1));
        check({tag, "_data"}, 64'(req_data), 64'(data));
        check({tag, "_addr"}, 64'(req_addr), 64'(addr));
        check({tag, "_sel"}, 64'(req_sel), 64'(sel));
        check({tag, "_write"}, 64'(req_write), 64'(1'b1));
        check({tag, "_last"}, 64'(req_last), 64'(last));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset
        #2 rst_n = 1'b0;
        tick();
        check("rst_frame_ready", 64'(frame_ready), 64'(1'b0));
        check("rst_req_valid", 64'(req_valid), 64'(1'b0));
        check("rst_req_data", 64'(req_data), 64'(0));
        check("rst_req_sel", 64'(req_sel), 64'(0));
        check("rst_cfg_valid", 64'(cfg_valid), 64'(1'b0));
        check("rst_err", 64'(err), 64'(1'b0));
        tick();
        rst_n = 1'b1;
        check("rst_release_ready_low", 64'(frame_ready), 64'(1'b0));
        tick();
        check("post_rst_ready", 64'(frame_ready), 64'(1'b1));

        // Basic write: three words from two frames
        req_ready = 1'b1;
        send_header(7'd2, 7'd3, 7'h10, 1'b1);
        check("wr_hdr_ready", 64'(frame_ready), 64'(1'b1));
        check("wr_hdr_novalid", 64'(req_valid), 64'(1'b0));
        send_frame(48'hAAAA_BBBB_CCCC);
        check("wr_busy_ready", 64'(frame_ready), 64'(1'b0));
        tick();
        check("wr_p1_novalid", 64'(req_valid), 64'(1'b0));
        tick();
        check_req("wr_w0", 32'hAAAA_BBBB, 7'h10, 4'b0100, 1'b0);
        tick();
        check("wr_w0_done", 64'(req_valid), 64'(1'b0));
        check("wr_buf_empty", 64'(frame_ready), 64'(1'b1));
        send_frame(48'hDDDD_EEEE_FFFF);
        tick();
        check_req("wr_w1", 32'hCCCC_DDDD, 7'h11, 4'b0100, 1'b0);
        tick();
        check("wr_w1_done", 64'(req_valid), 64'(1'b0));
        tick();
        check_req("wr_w2", 32'hEEEE_FFFF, 7'h12, 4'b0100, 1'b1);
        tick();
        check("wr_end_valid", 64'(req_valid), 64'(1'b0));
        check("wr_end_ready", 64'(frame_ready), 64'(1'b1));

        // Discard leftover chunks
        send_header(7'd1, 7'd2, 7'h30, 1'b1);
        send_frame(48'h1111_2222_3333);
        tick();
        tick();
        check_req("dis_w0", 32'h1111_2222, 7'h30, 4'b0010, 1'b0);
        tick();
        send_frame(48'h4444_5555_6666);
        tick();
        check_req("dis_w1", 32'h3333_4444, 7'h31, 4'b0010, 1'b1);
        tick();
        check("dis_idle_ready", 64'(frame_ready), 64'(1'b1));
        check("dis_idle_valid", 64'(req_valid), 64'(1'b0));
        tick();
        tick();
        check("dis_no_more", 64'(req_valid), 64'(1'b0));

        // Back-pressure and address wrap
        req_ready = 1'b0;
        send_header(7'd3, 7'd2, 7'h7F, 1'b1);
        send_frame(48'h0123_4567_89AB);
        tick();
        tick();
        check_req("bp_w0", 32'h0123_4567, 7'h7F, 4'b1000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", 64'(req_valid), 64'(1'b1));
            check("bp_hold_data", 64'(req_data), 64'(32'h0123_4567));
            check("bp_hold_addr", 64'(req_addr), 64'(7'h7F));
            check("bp_stall_ready", 64'(frame_ready), 64'(1'b0));
        end
        req_ready = 1'b1;
        tick();
        check("bp_w0_done", 64'(req_valid), 64'(1'b0));
        check("bp_buf_empty", 64'(frame_ready), 64'(1'b1));
        send_frame(48'hCDEF_0000_1111);
        tick();
        check_req("bp_w1", 32'h89AB_CDEF, 7'h00, 4'b1000, 1'b1);
        tick();
        check("bp_end_valid", 64'(req_valid), 64'(1'b0));
        check("bp_end_ready", 64'(frame_ready), 64'(1'b1));

        // Read: four back-to-back requests
        send_header(7'd0, 7'd4, 7'h20, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("rd_valid", 64'(req_valid), 64'(1'b1));
            check("rd_addr", 64'(req_addr), 64'(32'h20 + i));
            check("rd_write", 64'(req_write), 64'(1'b0));
            check("rd_data", 64'(req_data), 64'(0));
            check("rd_sel", 64'(req_sel), 64'(4'b0001));
            check("rd_last", 64'(req_last), 64'(i == 3));
            check("rd_ready", 64'(frame_ready), 64'(1'b0));
            tick();
        end
        check("rd_end_valid", 64'(req_valid), 64'(1'b0));
        check("rd_end_ready", 64'(frame_ready), 64'(1'b1));

        // Config frame (cfg_sel wins over first_frame)
        frame_valid = 1'b1;
        first_frame = 1'b1;
        cfg_sel     = 1'b1;
        slv_id      = 7'd1;
        length      = 7'd2;
        wr_data     = 48'h00A5_A5A5_A5A5;
        tick();
        frame_valid = 1'b0;
        first_frame = 1'b0;
        cfg_sel     = 1'b0;
        check("cfg_valid", 64'(cfg_valid), 64'(1'b1));
        check("cfg_data", 64'(cfg_data), 64'(40'hA5_A5A5_A5A5));
        check("cfg_ready_low", 64'(frame_ready), 64'(1'b0));
        tick();
        tick();
        check("cfg_hold_valid", 64'(cfg_valid), 64'(1'b1));
        check("cfg_hold_data", 64'(cfg_data), 64'(40'hA5_A5A5_A5A5));
        check("cfg_no_req", 64'(req_valid), 64'(1'b0));
        cfg_ready = 1'b1;
        tick();
        cfg_ready = 1'b0;
        check("cfg_done", 64'(cfg_valid), 64'(1'b0));
        check("cfg_idle_ready", 64'(frame_ready), 64'(1'b1));

        // Bad slave id
        send_header(7'd5, 7'd2, 7'h40, 1'b1);
        check("err_pulse", 64'(err), 64'(1'b1));
        check("err_no_req", 64'(req_valid), 64'(1'b0));
        check("err_ready", 64'(frame_ready), 64'(1'b1));
        tick();
        check("err_one_cycle", 64'(err), 64'(1'b0));

        // Zero-length header stays idle; a following payload frame is dropped
        send_header(7'd1, 7'd0, 7'h50, 1'b1);
        check("len0_ready", 64'(frame_ready), 64'(1'b1));
        send_frame(48'h1111_2222_3333);
        check("len0_drop_ready", 64'(frame_ready), 64'(1'b1));
        tick();
        tick();
        check("len0_no_req", 64'(req_valid), 64'(1'b0));

        // Reset in the middle of a write
        send_header(7'd2, 7'd3, 7'h05, 1'b1);
        send_frame(48'hAAAA_BBBB_CCCC);
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 64'(frame_ready), 64'(1'b0));
        check("mid_rst_valid", 64'(req_valid), 64'(1'b0));
        check("mid_rst_addr", 64'(req_addr), 64'(0));
        check("mid_rst_sel", 64'(req_sel), 64'(0));
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_rst_idle_ready", 64'(frame_ready), 64'(1'b1));
        tick();
        tick();
        check("mid_rst_no_req", 64'(req_valid), 64'(1'b0));
        check("mid_rst_data", 64'(req_data), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
